// File: rtl/serial_defs.sv
// Shared state encodings for the serial word transmitter and the
// downstream serial complement stage it feeds.
package serial_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } tx_state_e;

  // Downstream serial two's-complement stage: copy bits until the first 1, then invert.
  typedef enum logic {
    CMP_COPY   = 1'b0,
    CMP_INVERT = 1'b1
  } cmp_state_e;

  localparam int GAP_CNT_W = 4;

endpackage

// File: rtl/serial_word_tx_if.sv
// Word-in / bit-out handshake bundle of the serial word transmitter.
interface serial_word_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  logic             x;
  logic             sof;
  logic             eof;
  logic             busy;

  modport master (
    output data_in, in_valid, flush,
    input  in_ready, x, sof, eof, busy
  );

  modport slave (
    input  data_in, in_valid, flush,
    output in_ready, x, sof, eof, busy
  );
endinterface

// File: rtl/serial_bit_counter.sv
// Up-counter with synchronous clear (priority over increment) and a
// terminal-count flag compared against a runtime terminal value.
module serial_bit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] term_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == term_i);
endmodule

// File: rtl/serial_word_tx.sv
// Serializes a parallel word LSB first, then idles for GAP_CYCLES before
// accepting the next word. Moore outputs decoded from registered state only.
module serial_word_tx
  import serial_defs::*;
#(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  serial_word_tx_if.slave  bus
);
  localparam int BW = $clog2(WIDTH);

  tx_state_e        state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;

  logic                 bit_clr, bit_inc, bit_tc;
  logic                 gap_clr, gap_inc, gap_tc;
  logic [BW-1:0]        bit_cnt;
  logic [GAP_CNT_W-1:0] gap_cnt;

  serial_bit_counter #(.W(BW)) u_bit_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (bit_clr),
    .inc_i  (bit_inc),
    .term_i (BW'(WIDTH-1)),
    .cnt_o  (bit_cnt),
    .tc_o   (bit_tc)
  );

  serial_bit_counter #(.W(GAP_CNT_W)) u_gap_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (gap_clr),
    .inc_i  (gap_inc),
    .term_i (GAP_CNT_W'(GAP_CYCLES-1)),
    .cnt_o  (gap_cnt),
    .tc_o   (gap_tc)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_clr = 1'b0;
    bit_inc = 1'b0;
    gap_clr = 1'b0;
    gap_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          shreg_d = bus.data_in;
          bit_clr = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
        if (bit_tc) begin
          bit_clr = 1'b1;
          gap_clr = 1'b1;
          state_d = ST_GAP;
        end else begin
          bit_inc = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_tc) begin
          gap_clr = 1'b1;
          state_d = ST_IDLE;
        end else begin
          gap_inc = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        shreg_d = '0;
        bit_clr = 1'b1;
        gap_clr = 1'b1;
      end
    endcase
    // Abort wins over everything, including a same-cycle acceptance.
    if (bus.flush) begin
      state_d = ST_IDLE;
      shreg_d = '0;
      bit_clr = 1'b1;
      gap_clr = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
    end
  end

  assign bus.in_ready = (state_q == ST_IDLE);
  assign bus.busy     = (state_q == ST_SHIFT) || (state_q == ST_GAP);
  assign bus.x        = (state_q == ST_SHIFT) && shreg_q[0];
  assign bus.sof      = (state_q == ST_SHIFT) && (bit_cnt == '0);
  assign bus.eof      = (state_q == ST_SHIFT) && bit_tc;

  logic unused_ok;
  assign unused_ok = ^gap_cnt;
endmodule

// File: doc/serial_word_tx.md
SERIAL_WORD_TX -- requirements
Module: serial_word_tx

Interface
REQ-001 Parameter: WIDTH, default 8, bits per word (legal range 2..32).
REQ-002 Parameter: GAP_CYCLES, default 1, idle cycles inserted after each word (legal range 1..15).
REQ-003 Port: clk  input  1  single clock; all state updates on posedge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: data_in  input  WIDTH  parallel word to serialize.
REQ-006 Port: in_valid  input  1  data_in holds a word to accept.
REQ-007 Port: in_ready  output  1  block can accept a word this cycle.
REQ-008 Port: flush  input  1  synchronous abort of the current word.
REQ-009 Port: x  output  1  serial bit stream, LSB first, for the downstream serial FSM.
REQ-010 Port: sof  output  1  high while x carries bit 0 of a word.
REQ-011 Port: eof  output  1  high while x carries bit WIDTH-1 of a word.
REQ-012 Port: busy  output  1  high in SHIFT and GAP states.

Function
REQ-013 Moore FSM with states IDLE, SHIFT and GAP; all outputs are decoded from registered state only.
REQ-014 IDLE: in_ready=1; on a clk edge with in_valid=1, the block loads data_in into the shift register, clears bit_cnt to 0 and enters SHIFT.
REQ-015 Latency: a word accepted at edge k drives bit i on x during cycle k+1+i, for i = 0..WIDTH-1.
REQ-016 SHIFT: x = shreg[0]; on each edge the shift register shifts right by one with 0 filling the MSB, and bit_cnt increments.
REQ-017 SHIFT with bit_cnt==WIDTH-1: on the next edge the FSM enters GAP and gap_cnt clears to 0.
REQ-018 GAP: x=0 and in_ready=0; gap_cnt increments each edge; at gap_cnt==GAP_CYCLES-1 the FSM returns to IDLE.
REQ-019 in_ready=0 in SHIFT and GAP; in_valid in those states is ignored, and data_in is not sampled.
REQ-020 x=0, sof=0 and eof=0 in IDLE and GAP.
REQ-021 sof = (state==SHIFT && bit_cnt==0); eof = (state==SHIFT && bit_cnt==WIDTH-1).
REQ-022 flush=1 in any state: next state is IDLE, the shift register and counters clear, and the word is not completed; flush has priority over acceptance.
REQ-023 flush=1 with in_valid=1 in IDLE: the word is not accepted.
REQ-024 bit_cnt width is clog2(WIDTH); gap_cnt is 4 bits; counters do not wrap within legal parameter ranges.
REQ-025 Unreachable state encodings recover to IDLE on the next edge.

Reset
REQ-026 With reset=0 the block is asynchronously forced to: state=IDLE, shreg=0, bit_cnt=0, gap_cnt=0.
REQ-027 Output values during reset: x=0, sof=0, eof=0, busy=0, in_ready=1.
REQ-028 Reset asserted mid-word discards the word; after release, no partial bits are emitted.
REQ-029 Reset release is synchronous to clk; the first acceptance occurs no earlier than the first edge after release.

Structure
REQ-030 The IDLE/SHIFT/GAP 2-bit state encodings live in the shared definitions file serial_defs, together with the serial-stage state constants.
REQ-031 One sub-module, serial_bit_counter (parameterized up-counter with clear and terminal-count flag), is instantiated twice: once as bit_cnt and once as gap_cnt.
REQ-032 The block's x output connects directly to the x input of the downstream serial complement FSM.

Verification
REQ-033 After reset release, data_in=8'hB4 with in_valid=1 for one cycle -> x sequence 0,0,1,0,1,1,0,1 over 8 cycles; sof on the first bit, eof on the eighth bit.
REQ-034 in_valid held high with words 8'hFF then 8'h01 -> exactly 1 GAP cycle with x=0 and in_ready=0 between the words; the second word starts with x=1, sof=1.
REQ-035 flush=1 during bit 3 of 8'hA5 -> busy=0 and in_ready=1 on the next cycle, and no eof pulse occurs.
REQ-036 reset=0 asserted asynchronously mid-word (between edges) -> x, sof, eof and busy go to 0 immediately, without waiting for a clk edge.
REQ-037 in_valid=1 while in SHIFT with a different data_in -> the in-flight word is unchanged and the new value is not captured.
REQ-038 WIDTH=2, GAP_CYCLES=3, data 2'b10 -> x=0 then x=1, followed by 3 GAP cycles, then in_ready=1.
